method_pipe_mac: RTL and testbench

- Parametrised successor to the fixed 5-bit start/result/check method block.
- Operand pairs are pushed through an action method into a small FIFO. A sequential shift-add multiplier consumes them and accumulates the products.
- A value method and an action-value method expose the accumulator.
- Serves as the next-generation method-port naming testcase and as a reusable MAC in method-interface testbenches.

---
 rtl/method_pipe_pkg.sv | 17 +
 rtl/method_pipe_mac_if.sv | 28 ++
 rtl/method_pipe_fifo.sv | 57 +++++
 rtl/method_pipe_mac.sv | 101 ++++++++++
 tb/tb_method_pipe_mac.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/method_pipe_pkg.sv
// Shared definitions for the method-port MAC: FSM state encodings and a
// width helper used for pointer and counter sizing.
// Imported by the operand FIFO and the MAC top.
package method_pipe_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'd0;  // waiting for an operand pair
  localparam logic [1:0] MUL  = 2'd1;  // shift-add multiply, WIDTH cycles
  localparam logic [1:0] ACC  = 2'd2;  // fold product into accumulator

  // Bit width needed to index v entries; at least 1 so that 2-entry
  // structures and 2-bit counters still get a real register.
  function automatic int clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/method_pipe_mac_if.sv
// Method-port bundle of the MAC: start (action), result (value) and
// check (action-value) methods with their enables and ready flags.
// master = caller side, slave = MAC side.
interface method_pipe_mac_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             EN_start;
  logic             RDY_start;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] result;
  logic             RDY_result;
  logic [WIDTH-1:0] d;
  logic             EN_check;
  logic [WIDTH-1:0] check;
  logic             RDY_check;

  modport master (
    output a, b, EN_start, c, d, EN_check,
    input  RDY_start, result, RDY_result, check, RDY_check
  );

  modport slave (
    input  a, b, EN_start, c, d, EN_check,
    output RDY_start, result, RDY_result, check, RDY_check
  );
endinterface

// File: rtl/method_pipe_fifo.sv
// Small operand FIFO; pointers wrap modulo DEPTH (power of two).
// Ports: clk/rst (async active-high), enq + enq_dat, deq, full, empty, head.
// A push is accepted when not full or when a pop happens in the same cycle.
module method_pipe_fifo
  import method_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  logic [DW-1:0] enq_dat,
  input  logic          deq,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int PW = clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_enq;
  logic          do_deq;

  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_deq = deq && !empty;
  // A pop frees the slot this same edge, so a full FIFO may still take a push.
  assign do_enq = enq && (!full || do_deq);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_dat;
  end

endmodule

// File: rtl/method_pipe_mac.sv
// Multiply-accumulate behind method ports: start queues (a,b), a shift-add
// multiplier consumes pairs and adds a*b into acc; result = acc+c and
// check = acc-d read it, and EN_check clears it. Ports: CLK, RST, io.
module method_pipe_mac
  import method_pipe_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input logic              CLK,
  input logic              RST,
  method_pipe_mac_if.slave io
);

  localparam int CNT_W = clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic [CNT_W-1:0] cnt;
  pair_t            enq_pair;
  pair_t            head_pair;
  logic             fifo_full;
  logic             fifo_empty;
  logic             quiescent;
  logic             do_push;
  logic             do_pop;
  logic             do_clear;

  assign enq_pair  = '{a: io.a, b: io.b};
  assign quiescent = (state == IDLE) && fifo_empty;
  assign do_push   = io.EN_start && !fifo_full;  // EN_start while full is dropped
  assign do_pop    = (state == IDLE) && !fifo_empty;
  assign do_clear  = io.EN_check && quiescent;   // EN_check while busy is dropped

  assign io.RDY_start  = !fifo_full;
  assign io.RDY_result = quiescent;
  assign io.RDY_check  = quiescent;
  assign io.result     = acc + io.c;
  assign io.check      = acc - io.d;

  method_pipe_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(pair_t))
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .enq     (do_push),
    .enq_dat (enq_pair),
    .deq     (do_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_pair)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // do_clear needs an empty FIFO, so it never coincides with a pop;
          // a pair pushed with the clear accumulates onto zero later.
          if (do_clear) acc <= '0;
          if (do_pop) begin
            mcand  <= head_pair.a;
            mplier <= head_pair.b;
            prod   <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ACC;
        end
        ACC: begin
          acc   <= acc + prod;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_method_pipe_mac.sv
// Bench for method_pipe_mac: directed scenarios on a WIDTH=5/DEPTH=4 instance
// and a randomised sweep on a WIDTH=8/DEPTH=2 instance, both on one clock.
// Expected accumulator values come from scoreboard queues filled at start.
`timescale 1ns/1ps
module tb_method_pipe_mac;

  localparam int W5 = 5;
  localparam int D5 = 4;
  localparam int W8 = 8;
  localparam int D8 = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  method_pipe_mac_if #(.WIDTH(W5)) if5 ();
  method_pipe_mac_if #(.WIDTH(W8)) if8 ();

  method_pipe_mac #(.WIDTH(W5), .DEPTH(D5)) dut5 (.CLK(CLK), .RST(RST), .io(if5));
  method_pipe_mac #(.WIDTH(W8), .DEPTH(D8)) dut8 (.CLK(CLK), .RST(RST), .io(if8));

  int n_checks = 0;
  int n_fail   = 0;

  logic [W5-1:0] acc_m;     // reference accumulator for the 5-bit instance
  logic [W5-1:0] sb5 [$];   // expected acc after each queued op
  logic [W5-1:0] exp5;

  always @(posedge CLK) begin
    if (!RST) begin
      assert (!(if5.EN_start && !if5.RDY_start)) else $error("protocol: EN_start while not ready (w5)");
      assert (!(if8.EN_start && !if8.RDY_start)) else $error("protocol: EN_start while not ready (w8)");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Push one pair on the 5-bit instance while it is known to have room.
  task automatic push5(input logic [W5-1:0] av, input logic [W5-1:0] bv);
    @(negedge CLK);
    if5.a = av; if5.b = bv; if5.EN_start = 1'b1;
    acc_m = acc_m + av * bv;
    sb5.push_back(acc_m);
    @(posedge CLK);
    @(negedge CLK);
    if5.EN_start = 1'b0;
  endtask

  // Count sampled cycles with RDY_result low until it rises (bounded).
  task automatic wait_q5(output int cycles, output bit ok);
    cycles = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (if5.RDY_result === 1'b1) begin ok = 1'b1; break; end
      @(negedge CLK);
      cycles++;
    end
  endtask

  task automatic test_reset();
    if5.a = '0; if5.b = '0; if5.EN_start = 1'b0; if5.EN_check = 1'b0;
    if5.c = 5'd1; if5.d = 5'd0;
    if8.a = '0; if8.b = '0; if8.EN_start = 1'b0; if8.EN_check = 1'b0;
    if8.c = 8'd0; if8.d = 8'd0;
    acc_m = '0;
    #1 RST = 1'b1;
    @(negedge CLK); #1;
    n_checks++; if (if5.RDY_start !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_start: got %b want 1", if5.RDY_start); end
    n_checks++; if (if5.RDY_result !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_result: got %b want 1", if5.RDY_result); end
    n_checks++; if (if5.RDY_check !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_check: got %b want 1", if5.RDY_check); end
    n_checks++; if (if5.result !== 5'd1) begin n_fail++; $display("FAIL reset_result: got %0d want 1", if5.result); end
    n_checks++; if (if5.check !== 5'd0) begin n_fail++; $display("FAIL reset_check: got %0d want 0", if5.check); end
    n_checks++; if (if8.RDY_start !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_start_w8: got %b want 1", if8.RDY_start); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_single();
    int cyc; bit ok;
    @(negedge CLK);
    if5.c = 5'd1; if5.d = 5'd0;
    push5(5'd3, 5'd4);
    wait_q5(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: RDY_result never rose"); end
    n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL single_latency: RDY_result low %0d cycles want 7", cyc); end
    exp5 = sb5.pop_front() + 5'd1;
    n_checks++; if (if5.result !== exp5) begin n_fail++; $display("FAIL single_result: got %0d want %0d", if5.result, exp5); end
    @(negedge CLK);
    if5.d = 5'd2; if5.EN_check = 1'b1;
    #1;
    n_checks++; if (if5.check !== 5'd10) begin n_fail++; $display("FAIL single_check: got %0d want 10", if5.check); end
    @(posedge CLK);
    @(negedge CLK);
    if5.EN_check = 1'b0; acc_m = '0;
    #1;
    n_checks++; if (if5.result !== 5'd1) begin n_fail++; $display("FAIL single_cleared: got %0d want 1", if5.result); end
  endtask

  task automatic test_overflow();
    int cyc; bit ok;
    @(negedge CLK);
    if5.c = 5'd0;
    push5(5'd7, 5'd7);
    wait_q5(cyc, ok);
    exp5 = sb5.pop_front();
    n_checks++; if (!ok || if5.result !== exp5) begin n_fail++; $display("FAIL ovf_7x7: got %0d want %0d", if5.result, exp5); end
    push5(5'd31, 5'd31);
    wait_q5(cyc, ok);
    exp5 = sb5.pop_front();
    n_checks++; if (!ok || if5.result !== exp5) begin n_fail++; $display("FAIL ovf_31x31: got %0d want %0d", if5.result, exp5); end
    @(negedge CLK);
    if5.d = 5'd20; if5.EN_check = 1'b1;
    #1;
    n_checks++; if (if5.check !== 5'd30) begin n_fail++; $display("FAIL ovf_check_wrap: got %0d want 30", if5.check); end
    @(posedge CLK);
    @(negedge CLK);
    if5.EN_check = 1'b0; acc_m = '0; if5.c = 5'd3;
    #1;
    n_checks++; if (if5.result !== 5'd3) begin n_fail++; $display("FAIL ovf_cleared: got %0d want 3", if5.result); end
  endtask

  task automatic test_back_to_back();
    int k, guard, cyc; bit saw_full, ok;
    k = 1; guard = 0; saw_full = 1'b0;
    if5.c = 5'd0;
    while (k <= 6 && guard < 100) begin
      @(negedge CLK);
      if (if5.RDY_start === 1'b1) begin
        if5.a = 5'd1; if5.b = 5'(k); if5.EN_start = 1'b1;
        acc_m = acc_m + 5'(k);
        sb5.push_back(acc_m);
        k++;
      end else begin
        if5.EN_start = 1'b0;
        saw_full = 1'b1;
      end
      guard++;
    end
    @(negedge CLK);
    if5.EN_start = 1'b0;
    n_checks++; if (k != 7) begin n_fail++; $display("FAIL b2b_pushes: pushed %0d want 6", k - 1); end
    n_checks++; if (!saw_full) begin n_fail++; $display("FAIL b2b_full: RDY_start never deasserted"); end
    wait_q5(cyc, ok);
    while (sb5.size() > 1) void'(sb5.pop_front());
    exp5 = sb5.pop_front();
    n_checks++; if (!ok || if5.result !== exp5) begin n_fail++; $display("FAIL b2b_acc: got %0d want %0d", if5.result, exp5); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    if5.c = 5'd1;
    push5(5'd3, 5'd4);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    n_checks++; if (if5.RDY_result !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: RDY_result got %b want 0", if5.RDY_result); end
    RST = 1'b1;
    #1;
    n_checks++; if (if5.RDY_result !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy: got %b want 1", if5.RDY_result); end
    n_checks++; if (if5.result !== 5'd1) begin n_fail++; $display("FAIL rstmid_acc: result got %0d want 1", if5.result); end
    sb5.delete(); acc_m = '0;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge CLK);
    #1;
    n_checks++; if (if5.RDY_result !== 1'b1 || if5.result !== 5'd1) begin
      n_fail++; $display("FAIL rstmid_discard: rdy %b result %0d want 1/1", if5.RDY_result, if5.result);
    end
  endtask

  task automatic test_check_start();
    int cyc; bit ok;
    @(negedge CLK);
    if5.c = 5'd0;
    push5(5'd3, 5'd3);
    wait_q5(cyc, ok);
    exp5 = sb5.pop_front();
    n_checks++; if (!ok || if5.result !== exp5) begin n_fail++; $display("FAIL cs_setup: got %0d want %0d", if5.result, exp5); end
    @(negedge CLK);
    if5.d = 5'd0; if5.EN_check = 1'b1;
    if5.a = 5'd2; if5.b = 5'd3; if5.EN_start = 1'b1;
    acc_m = '0;
    acc_m = acc_m + 5'd6;
    sb5.push_back(acc_m);
    #1;
    n_checks++; if (if5.check !== 5'd9) begin n_fail++; $display("FAIL cs_check: got %0d want 9", if5.check); end
    @(posedge CLK);
    @(negedge CLK);
    if5.EN_check = 1'b0; if5.EN_start = 1'b0;
    wait_q5(cyc, ok);
    n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL cs_latency: got %0d want 7", cyc); end
    exp5 = sb5.pop_front();
    n_checks++; if (!ok || if5.result !== exp5) begin n_fail++; $display("FAIL cs_acc: got %0d want %0d", if5.result, exp5); end
  endtask

  task automatic test_sweep();
    int occ, busy, pushes, guard;
    bit en, pop;
    logic [W8-1:0] av, bv, cv, sum8, exp_acc;
    logic [W8-1:0] sb8 [$];
    occ = 0; busy = 0; pushes = 0; guard = 0;
    sum8 = '0; exp_acc = '0; cv = '0;
    while ((pushes < 200 || occ != 0 || busy != 0) && guard < 20000) begin
      @(negedge CLK);
      av = 8'($urandom); bv = 8'($urandom); cv = 8'($urandom);
      en = (pushes < 200) && (occ != D8) && ($urandom_range(0, 3) != 0);
      if8.a = av; if8.b = bv; if8.c = cv; if8.EN_start = en;
      #1;
      n_checks++; if (if8.RDY_start !== (occ != D8)) begin n_fail++; $display("FAIL sweep_rdy_start: got %b occ %0d", if8.RDY_start, occ); end
      n_checks++; if (if8.RDY_result !== (occ == 0 && busy == 0)) begin n_fail++; $display("FAIL sweep_rdy_result: got %b occ %0d busy %0d", if8.RDY_result, occ, busy); end
      if (occ == 0 && busy == 0) begin
        while (sb8.size() > 0) exp_acc = sb8.pop_front();
        n_checks++; if (if8.result !== exp_acc + cv) begin n_fail++; $display("FAIL sweep_acc: got %0d want %0d", if8.result, exp_acc + cv); end
      end
      @(posedge CLK);
      pop = (busy == 0) && (occ > 0);
      if (pop) busy = W8 + 1;
      else if (busy > 0) busy--;
      occ = occ + (en ? 1 : 0) - (pop ? 1 : 0);
      if (en) begin
        sum8 = sum8 + av * bv;
        sb8.push_back(sum8);
        pushes++;
      end
      guard++;
    end
    @(negedge CLK);
    if8.EN_start = 1'b0; if8.c = 8'd0;
    #1;
    n_checks++; if (guard >= 20000) begin n_fail++; $display("FAIL sweep_timeout: %0d ops issued", pushes); end
    while (sb8.size() > 0) exp_acc = sb8.pop_front();
    n_checks++; if (if8.RDY_result !== 1'b1 || if8.result !== exp_acc) begin
      n_fail++; $display("FAIL sweep_final: rdy %b acc %0d want %0d", if8.RDY_result, if8.result, exp_acc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_check_start();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
